// File: rtl/exp_pkg.sv
// Shared definitions for the exponent accelerator job driver.
// Register word map, ctrl bit positions and driver FSM states.
package exp_pkg;

  localparam logic [3:0] EXP_ADDR_X    = 4'd0;
  localparam logic [3:0] EXP_ADDR_A    = 4'd1;
  localparam logic [3:0] EXP_ADDR_P    = 4'd2;
  localparam logic [3:0] EXP_ADDR_CTRL = 4'd3;

  localparam int EXP_CTRL_DONE  = 0;
  localparam int EXP_CTRL_START = 1;

  localparam logic [31:0] EXP_CTRL_GO  = 32'h2;
  localparam logic [31:0] EXP_CTRL_CLR = 32'h0;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_X,
    S_WR_A,
    S_WR_START,
    S_POLL_RD,
    S_POLL_CHK,
    S_POLL_WAIT,
    S_CLR_START,
    S_RD_P,
    S_RD_P_CAP,
    S_ABORT,
    S_OUT
  } exp_drv_state_t;

endpackage

// File: rtl/exp_poll_timer.sv
// Poll pacing for the job driver: loadable inter-poll gap counter
// and a saturating poll timeout counter.
module exp_poll_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned POLL_GAP       = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tmo_clr,
  input  logic tmo_en,
  input  logic gap_load,
  input  logic gap_en,
  output logic gap_done,
  output logic timed_out
);

  localparam logic [31:0] GAP_LD =
    (POLL_GAP == 0) ? 32'd0 : 32'(POLL_GAP - 1);
  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  logic [31:0] tmo_cnt;
  logic [31:0] gap_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (tmo_clr)
        tmo_cnt <= '0;
      else if (tmo_en && tmo_cnt != '1)
        tmo_cnt <= tmo_cnt + 32'd1;
      if (gap_load)
        gap_cnt <= GAP_LD;
      else if (gap_en && gap_cnt != '0)
        gap_cnt <= gap_cnt - 32'd1;
    end
  end

  assign gap_done  = (gap_cnt == '0);
  assign timed_out = (tmo_cnt >= TMO);

endmodule

// File: rtl/exp_job_driver.sv
// Job driver for the exponent accelerator register window.
// Optional perf_cycles output enabled by EXP_JOB_DRIVER_PERF_EN.
module exp_job_driver
  import exp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned POLL_GAP       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_x,
  input  logic [31:0] job_a,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_p,
  output logic        res_timeout,
  output logic [3:0]  bus_address,
  output logic        bus_write,
  output logic [31:0] bus_writedata,
  output logic        bus_read,
  input  logic [31:0] bus_readdata,
  output logic        busy
`ifdef EXP_JOB_DRIVER_PERF_EN
  ,
  output logic [31:0] perf_cycles
`endif
);

  exp_drv_state_t state, state_n;
  logic [31:0] a_q;
  logic gap_done, timed_out;
  logic polling;

  assign polling = (state == S_POLL_RD) ||
                   (state == S_POLL_CHK) ||
                   (state == S_POLL_WAIT);

  exp_poll_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .POLL_GAP      (POLL_GAP)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .tmo_clr  (state == S_WR_START),
    .tmo_en   (polling),
    .gap_load (state == S_POLL_CHK),
    .gap_en   (state == S_POLL_WAIT),
    .gap_done (gap_done),
    .timed_out(timed_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:      if (job_valid) state_n = S_WR_X;
      S_WR_X:      state_n = S_WR_A;
      S_WR_A:      state_n = S_WR_START;
      S_WR_START:  state_n = S_POLL_RD;
      S_POLL_RD:   state_n = S_POLL_CHK;
      S_POLL_CHK: begin
        if (bus_readdata[EXP_CTRL_DONE])
          state_n = S_CLR_START;
        else if (timed_out)
          state_n = S_ABORT;
        else if (POLL_GAP == 0)
          state_n = S_POLL_RD;
        else
          state_n = S_POLL_WAIT;
      end
      S_POLL_WAIT: if (gap_done) state_n = S_POLL_RD;
      S_CLR_START: state_n = S_RD_P;
      S_RD_P:      state_n = S_RD_P_CAP;
      S_RD_P_CAP:  state_n = S_OUT;
      S_ABORT:     state_n = S_OUT;
      S_OUT:       if (res_ready) state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q           <= '0;
      bus_write     <= 1'b0;
      bus_read      <= 1'b0;
      bus_address   <= '0;
      bus_writedata <= '0;
      res_p         <= '0;
      res_timeout   <= 1'b0;
    end else begin
      bus_write <= 1'b0;
      bus_read  <= 1'b0;
      if (job_valid && job_ready)
        a_q <= job_a;
      unique case (state_n)
        S_WR_X: begin
          bus_write     <= 1'b1;
          bus_address   <= EXP_ADDR_X;
          bus_writedata <= job_x;
        end
        S_WR_A: begin
          bus_write     <= 1'b1;
          bus_address   <= EXP_ADDR_A;
          bus_writedata <= a_q;
        end
        S_WR_START: begin
          bus_write     <= 1'b1;
          bus_address   <= EXP_ADDR_CTRL;
          bus_writedata <= EXP_CTRL_GO;
        end
        S_CLR_START, S_ABORT: begin
          bus_write     <= 1'b1;
          bus_address   <= EXP_ADDR_CTRL;
          bus_writedata <= EXP_CTRL_CLR;
        end
        S_POLL_RD: begin
          bus_read    <= 1'b1;
          bus_address <= EXP_ADDR_CTRL;
        end
        S_RD_P: begin
          bus_read    <= 1'b1;
          bus_address <= EXP_ADDR_P;
        end
        default: ;
      endcase
      if (state == S_RD_P_CAP) begin
        res_p       <= bus_readdata;
        res_timeout <= 1'b0;
      end else if (state == S_ABORT) begin
        res_p       <= '0;
        res_timeout <= 1'b1;
      end
    end
  end

  assign job_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_OUT);

`ifdef EXP_JOB_DRIVER_PERF_EN
  logic [31:0] perf_cnt;
  logic [31:0] perf_inc;

  assign perf_inc = (perf_cnt == '1) ? perf_cnt : perf_cnt + 32'd1;

  // perf_cnt holds cycles spent before the current one since WR_START.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt    <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == S_WR_START)
        perf_cnt <= 32'd1;
      else if (busy && state != S_OUT)
        perf_cnt <= perf_inc;
      if (state != S_OUT && state_n == S_OUT)
        perf_cycles <= perf_inc;
    end
  end
`endif

endmodule

// File: tb/tb_exp_job_driver.sv
// Directed bench for exp_job_driver with a small register bank model.
// Build with EXP_JOB_DRIVER_PERF_EN to also exercise perf_cycles.
module tb_exp_job_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid = 1'b0;
  logic        job_ready;
  logic [31:0] job_x = '0;
  logic [31:0] job_a = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_p;
  logic        res_timeout;
  logic [3:0]  bus_address;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic        bus_read;
  logic [31:0] bus_readdata = '0;
  logic        busy;
`ifdef EXP_JOB_DRIVER_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int n_checks = 0;
  int n_fail = 0;

  int cyc = 0;
  int hs_cyc = 0;
  int ws_cyc = 0;
  int rv_cyc = 0;
  logic rv_q = 1'b0;
  int poll_n = 0;
  int done_at = 0;
  logic [31:0] p_val = '0;
  logic [35:0] wr_q[$];
  logic [3:0]  rd_q[$];

  exp_job_driver #(
    .TIMEOUT_CYCLES(20),
    .POLL_GAP      (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_x        (job_x),
    .job_a        (job_a),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_p        (res_p),
    .res_timeout  (res_timeout),
    .bus_address  (bus_address),
    .bus_write    (bus_write),
    .bus_writedata(bus_writedata),
    .bus_read     (bus_read),
    .bus_readdata (bus_readdata),
    .busy         (busy)
`ifdef EXP_JOB_DRIVER_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Bank model: read data valid exactly one cycle after bus_read.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    rv_q <= res_valid;
    if (res_valid && !rv_q) rv_cyc <= cyc;
    if (job_valid && job_ready) begin
      hs_cyc <= cyc;
      poll_n <= 0;
    end
    if (bus_write) begin
      wr_q.push_back({bus_address, bus_writedata});
      if (bus_address == 4'd3 && bus_writedata == 32'h2)
        ws_cyc <= cyc;
    end
    if (bus_read) begin
      rd_q.push_back(bus_address);
      if (bus_address == 4'd3) begin
        poll_n <= poll_n + 1;
        bus_readdata <= {31'h7FFF_FFFF,
                         done_at != 0 && poll_n + 1 >= done_at};
      end else if (bus_address == 4'd2)
        bus_readdata <= p_val;
      else
        bus_readdata <= 32'h0;
    end else begin
      bus_readdata <= 32'hFFFF_FFFF;
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_job(input logic [31:0] x,
                          input logic [31:0] a);
    @(negedge clk);
    check("job_ready_offer", job_ready, 1);
    job_x = x;
    job_a = a;
    job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    for (int i = 0; i < 400; i++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    check(tag, res_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, n2, n3, ws, rs;

    repeat (3) @(negedge clk);
    check("rst_job_ready", job_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_p", res_p, 0);
    check("rst_res_timeout", res_timeout, 0);
    check("rst_bus_write", bus_write, 0);
    check("rst_bus_read", bus_read, 0);
    check("rst_bus_address", bus_address, 0);
    check("rst_bus_writedata", bus_writedata, 0);
    check("rst_busy", busy, 0);
`ifdef EXP_JOB_DRIVER_PERF_EN
    check("rst_perf", perf_cycles, 0);
`endif
    rst_n = 1'b1;

    // Job 3^5, done reported on the 4th poll.
    done_at = 4;
    p_val = 32'd243;
    wb = wr_q.size();
    rb = rd_q.size();
    send_job(32'd3, 32'd5);
    check("t1_busy", busy, 1);
    wait_res("t1_res_wait");
    check("t1_nwr", wr_q.size() - wb, 4);
    check("t1_wr0", wr_q[wb],     {4'd0, 32'd3});
    check("t1_wr1", wr_q[wb + 1], {4'd1, 32'd5});
    check("t1_wr2", wr_q[wb + 2], {4'd3, 32'h2});
    check("t1_wr3", wr_q[wb + 3], {4'd3, 32'h0});
    check("t1_nrd", rd_q.size() - rb, 5);
    for (int i = 0; i < 4; i++)
      check("t1_rd_ctrl", rd_q[rb + i], 3);
    check("t1_rd_p", rd_q[rb + 4], 2);
    check("t1_res_p", res_p, 243);
    check("t1_res_tmo", res_timeout, 0);
    res_ready = 1'b1;
    @(negedge clk);
    check("t1_rv_drop", res_valid, 0);
    check("t1_ready_back", job_ready, 1);

    // Done at the first poll, consumer always ready.
    done_at = 1;
    p_val = 32'hDEAD_BEEF;
    send_job(32'd2, 32'd31);
    wait_res("t2_res_wait");
    check("t2_res_p", res_p, 32'hDEAD_BEEF);
    check("t2_res_tmo", res_timeout, 0);
    @(negedge clk);
    check("t2_latency", rv_cyc - hs_cyc - 1, 8);
    check("t2_rv_1cyc", res_valid, 0);
    check("t2_ready_next", job_ready, 1);

    // Done never set: abort after the poll budget.
    res_ready = 1'b0;
    done_at = 0;
    wb = wr_q.size();
    rb = rd_q.size();
    send_job(32'd7, 32'd9);
    wait_res("t3_res_wait");
    check("t3_res_tmo", res_timeout, 1);
    check("t3_res_p", res_p, 0);
    check("t3_last_wr", wr_q[wr_q.size() - 1], {4'd3, 32'h0});
    n2 = 0;
    n3 = 0;
    for (int i = rb; i < rd_q.size(); i++) begin
      if (rd_q[i] == 4'd2) n2++;
      if (rd_q[i] == 4'd3) n3++;
    end
    check("t3_no_rd_p", n2, 0);
    check("t3_polls", n3, 6);

    // Consumer stalls: outputs hold, new jobs are refused.
    ws = wr_q.size();
    rs = rd_q.size();
    for (int i = 0; i < 10; i++) begin
      job_valid = i[0];
      job_x = 32'h1000 + i;
      @(negedge clk);
      check("t4_rv", res_valid, 1);
      check("t4_res_p", res_p, 0);
      check("t4_res_tmo", res_timeout, 1);
      check("t4_job_ready", job_ready, 0);
    end
    job_valid = 1'b0;
    check("t4_no_bus", (wr_q.size() - ws) + (rd_q.size() - rs), 0);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("t4_idle", busy, 0);

    // Reset while waiting between polls.
    done_at = 0;
    send_job(32'd4, 32'd4);
    for (int i = 0; i < 50; i++) begin
      if (bus_read) break;
      @(negedge clk);
    end
    check("t5_poll_seen", bus_read, 1);
    @(negedge clk);
    @(negedge clk);
    check("t5_in_wait", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_job_ready", job_ready, 1);
    check("t5_busy", busy, 0);
    check("t5_bus_write", bus_write, 0);
    check("t5_bus_read", bus_read, 0);
    check("t5_bus_address", bus_address, 0);
    check("t5_bus_writedata", bus_writedata, 0);
    check("t5_res_valid", res_valid, 0);
    check("t5_res_p", res_p, 0);
    rst_n = 1'b1;
    ws = wr_q.size();
    rs = rd_q.size();
    repeat (6) @(negedge clk);
    check("t5_bus_quiet", (wr_q.size() - ws) + (rd_q.size() - rs), 0);

`ifdef EXP_JOB_DRIVER_PERF_EN
    // Done on the 3rd poll with a 2-cycle poll gap.
    done_at = 3;
    p_val = 32'd64;
    send_job(32'd2, 32'd6);
    wait_res("t6_res_wait");
    @(negedge clk);
    check("t6_perf_meas", perf_cycles, rv_cyc - ws_cyc);
    check("t6_perf_abs", perf_cycles, 14);
    check("t6_res_p", res_p, 64);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
